// File: rtl/multicycle_adder_ctrl_pkg.sv
// ============================================================================
// multicycle_adder_ctrl_pkg : shared state encoding and index-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package multicycle_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Chunk index needs at least one bit even when a single chunk is used.
  function automatic int calc_idx_w(input int num_chunks);
    return (num_chunks <= 2) ? 1 : $clog2(num_chunks);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_adder_ctrl_chunk_adder.sv
// ============================================================================
// chunk_adder : combinational CHUNK-bit a + b + cin slice with carry-out
// Rev 1.0
// ============================================================================
`default_nettype none

module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/multicycle_adder_ctrl.sv
// ============================================================================
// multicycle_adder_ctrl : WIDTH-bit add/sub sequenced over one CHUNK-bit slice
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_adder_ctrl
  import multicycle_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             op_sub,
  input  logic             abort,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W      = calc_idx_w(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_width
    $error("multicycle_adder_ctrl: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             accept;
  logic             last_chunk;

  // Operand chunk select driven by the running index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_chunk = a_reg[i*CHUNK +: CHUNK];
        b_chunk = b_reg[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_nxt    = state;
    start_ready  = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    accept       = 1'b0;
    last_chunk   = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        accept      = start_valid && !abort;
        if (accept) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        last_chunk = (idx == LAST_IDX);
        if (abort)           state_nxt = ST_IDLE;
        else if (last_chunk) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        result_valid = 1'b1;
        if (abort || result_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg <= a;
        b_reg <= op_sub ? ~b : b;
        carry <= op_sub | carry_in;
        idx   <= '0;
      end else if (state == ST_RUN) begin
        if (abort) begin
          idx <= '0;
        end else begin
          for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == IDX_W'(i)) sum[i*CHUNK +: CHUNK] <= slice_sum;
          end
          carry <= slice_cout;
          if (last_chunk) begin
            idx       <= '0;
            carry_out <= slice_cout;
            // Final sum MSB is the slice MSB being written on this edge.
            overflow  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                         (slice_sum[CHUNK-1] != a_reg[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_adder_ctrl.sv
// ============================================================================
// tb_multicycle_adder_ctrl : scoreboard bench, two instances (CHUNK 8 and 32)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_adder_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_valid  [2];
  logic        start_ready  [2];
  logic [31:0] a_in         [2];
  logic [31:0] b_in         [2];
  logic        carry_in     [2];
  logic        op_sub       [2];
  logic        abort        [2];
  logic        busy         [2];
  logic        result_valid [2];
  logic        result_ready [2];
  logic [31:0] sum          [2];
  logic        carry_out    [2];
  logic        overflow     [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Reference: plain wide arithmetic and signed range test.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sb, input int acc);
    exp_t        e;
    logic [63:0] full;
    longint      sa, sbv, sres;
    full  = {32'd0, av} + {32'd0, (sb ? ~bv : bv)} + {63'd0, (sb ? 1'b1 : ci)};
    sa    = $signed(av);
    sbv   = $signed(bv);
    sres  = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
    e.sum  = full[31:0];
    e.cout = full[32];
    e.ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    e.acc  = acc;
    return e;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int CH = (k == 0) ? 8 : 32;
    localparam int NC = 32 / CH;

    multicycle_adder_ctrl #(.WIDTH(32), .CHUNK(CH)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_valid  (start_valid[k]),
      .start_ready  (start_ready[k]),
      .a            (a_in[k]),
      .b            (b_in[k]),
      .carry_in     (carry_in[k]),
      .op_sub       (op_sub[k]),
      .abort        (abort[k]),
      .busy         (busy[k]),
      .result_valid (result_valid[k]),
      .result_ready (result_ready[k]),
      .sum          (sum[k]),
      .carry_out    (carry_out[k]),
      .overflow     (overflow[k])
    );

    exp_t q[$];

    always @(negedge clk) begin
      bit was_empty;
      int d;
      if (!rst_n) begin
        q.delete();
      end else begin
        was_empty = (q.size() == 0);
        chk("start_ready", start_ready[k], was_empty);
        chk("busy", busy[k], !was_empty);
        if (was_empty) begin
          chk("result_valid_idle", result_valid[k], 1'b0);
        end else begin
          d = cyc - q[0].acc;
          if (d <= NC) chk("result_valid_timing", result_valid[k], d == NC);
          if (result_valid[k]) begin
            chk("sum", sum[k], q[0].sum);
            chk("carry_out", carry_out[k], q[0].cout);
            chk("overflow", overflow[k], q[0].ovf);
          end
          if (abort[k]) void'(q.pop_front());
          else if (result_valid[k] && result_ready[k]) void'(q.pop_front());
        end
        if (was_empty && start_valid[k] && !abort[k])
          q.push_back(model(a_in[k], b_in[k], carry_in[k], op_sub[k], cyc + 1));
      end
    end
  end

  task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic sb, input int stall);
    int t;
    @(posedge clk); #1;
    start_valid[k] = 1'b1;
    a_in[k] = av; b_in[k] = bv; carry_in[k] = ci; op_sub[k] = sb;
    t = 0;
    while (!start_ready[k]) begin
      @(posedge clk); #1;
      if (++t > 50) begin fail_now("accept_wait"); start_valid[k] = 1'b0; return; end
    end
    @(posedge clk); #1;
    start_valid[k] = 1'b0;
    a_in[k] = $urandom(); b_in[k] = $urandom();
    carry_in[k] = 1'($urandom()); op_sub[k] = 1'($urandom());
    result_ready[k] = (stall == 0);
    t = 0;
    while (!result_valid[k]) begin
      @(posedge clk); #1;
      if (++t > 50) begin fail_now("result_wait"); result_ready[k] = 1'b0; return; end
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      start_valid[k] = 1'($urandom());
      a_in[k] = $urandom(); b_in[k] = $urandom();
    end
    start_valid[k]  = 1'b0;
    result_ready[k] = 1'b1;
    @(posedge clk); #1;
    result_ready[k] = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic rand_ops(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      do_op(k, pick(), pick(), 1'($urandom()), 1'($urandom()),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    fail_now("global_watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_valid[k] = 0; a_in[k] = 0; b_in[k] = 0; carry_in[k] = 0;
      op_sub[k] = 0; abort[k] = 0; result_ready[k] = 0;
    end
    #12;
    chk("rst_sum", sum[0], 32'd0);
    chk("rst_cout", carry_out[0], 1'b0);
    chk("rst_ovf", overflow[0], 1'b0);
    chk("rst_valid", result_valid[0], 1'b0);
    chk("rst_busy", busy[0], 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;

    do_op(0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 0);
    do_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1);
    do_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
    do_op(0, 32'h5, 32'h7, 1'b0, 1'b1, 2);
    do_op(0, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 0);
    do_op(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 10);

    // Abort at chunk index 2.
    @(posedge clk); #1;
    start_valid[0] = 1'b1; a_in[0] = 32'hDEAD_BEEF; b_in[0] = 32'h0101_0101;
    @(posedge clk); #1 start_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_valid", result_valid[0], 1'b0);
    repeat (6) @(posedge clk);

    // Abort beats start_valid in IDLE.
    #1 start_valid[0] = 1'b1; abort[0] = 1'b1;
    @(posedge clk); #1 start_valid[0] = 1'b0; abort[0] = 1'b0;
    chk("abort_idle_busy", busy[0], 1'b0);

    // Abort beats result_ready in DONE.
    @(posedge clk); #1;
    start_valid[0] = 1'b1; a_in[0] = 32'h1; b_in[0] = 32'h2;
    @(posedge clk); #1 start_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 abort[0] = 1'b1; result_ready[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0; result_ready[0] = 1'b0;
    chk("abort_done_valid", result_valid[0], 1'b0);
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-RUN.
    #1 start_valid[0] = 1'b1; a_in[0] = 32'h1234_5678; b_in[0] = 32'h1111_1111;
    @(posedge clk); #1 start_valid[0] = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum[0], 32'd0);
    chk("mid_rst_cout", carry_out[0], 1'b0);
    chk("mid_rst_ovf", overflow[0], 1'b0);
    chk("mid_rst_valid", result_valid[0], 1'b0);
    chk("mid_rst_busy", busy[0], 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    do_op(0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 0);
    do_op(0, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1);

    fork
      rand_ops(0, 500);
      rand_ops(1, 500);
    join
    repeat (5) @(posedge clk);
    chk("drained0", g_dut[0].q.size(), 0);
    chk("drained1", g_dut[1].q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
